// File: rtl/ra_lcb_cal_if.sv
// ra_lcb_cal_if: handshake and configuration bundle between the LCB
// calibration controller and its requester / replica strobe detector.
// Width of the configuration word comes from LCBSDR_CONFIGWIDTH.

`ifndef LCBSDR_CONFIGWIDTH
`define LCBSDR_CONFIGWIDTH 4
`endif

interface ra_lcb_cal_if;
   logic                            start;
   logic                            fb;
   logic [0:`LCBSDR_CONFIGWIDTH-1]  cfg;
   logic                            busy;
   logic                            done;
   logic                            fail;

   // requester side: asks for calibration, supplies detector feedback
   modport master (
      output start,
      output fb,
      input  cfg,
      input  busy,
      input  done,
      input  fail
   );

   // controller side
   modport slave (
      input  start,
      input  fb,
      output cfg,
      output busy,
      output done,
      output fail
   );
endinterface

// File: rtl/ra_lcb_cal.sv
// ra_lcb_cal: calibration controller for the array local clock buffer.
// Sweeps the LCB configuration word upward from 0, lets each setting settle,
// counts good replica-strobe samples, and locks the first setting whose
// samples are all good. If none passes, it parks at all-ones and flags fail.
// Optional feature macro: LCBCAL_MARGIN_EN adds a saturating guard band of
// MARGIN steps to the locked setting; without it no adder is built.

`ifndef LCBSDR_CONFIGWIDTH
`define LCBSDR_CONFIGWIDTH 4
`endif

module ra_lcb_cal #(
   parameter int SETTLE  = 4,
   parameter int SAMPLES = 8,
   parameter int MARGIN  = 1
) (
   input  logic         clk,
   input  logic         reset,
   ra_lcb_cal_if.slave  cal
);

   localparam int W      = `LCBSDR_CONFIGWIDTH;
   localparam int MAXC   = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
   localparam int CNT_W  = $clog2(MAXC + 1);
   localparam int HIT_W  = $clog2(SAMPLES + 1);
   localparam logic [0:W-1] ALL_ONES = {W{1'b1}};
   localparam logic [0:W-1] ZERO     = {W{1'b0}};

   // Parameter sanity, evaluated once at elaboration.
   if (SETTLE < 1 || SAMPLES < 1 || MARGIN < 0) begin : g_bad_param
      $error("ra_lcb_cal: SETTLE and SAMPLES must be >= 1, MARGIN >= 0");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_SAMPLE = 3'd2,
      S_EVAL   = 3'd3,
      S_DONE   = 3'd4,
      S_FAIL   = 3'd5
   } state_t;

   state_t              state_r;
   logic [0:W-1]        cfg_r;
   logic                busy_r;
   logic                done_r;
   logic                fail_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [HIT_W-1:0]    hits_r;

   // Value written to cfg when setting k passes; saturates, never wraps.
   function automatic logic [0:W-1] lock_value(input logic [0:W-1] k);
`ifdef LCBCAL_MARGIN_EN
      logic [31:0] sum;
      sum = 32'(k) + 32'(MARGIN);
      if (sum > 32'(ALL_ONES)) begin
         return ALL_ONES;
      end else begin
         return W'(sum);
      end
`else
      return k;
`endif
   endfunction

   assign cal.cfg  = cfg_r;
   assign cal.busy = busy_r;
   assign cal.done = done_r;
   assign cal.fail = fail_r;

   // Sweep state machine; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         cfg_r   <= ZERO;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         fail_r  <= 1'b0;
         cnt_r   <= '0;
         hits_r  <= '0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE, S_FAIL: begin
               // start only acts here, so a held start cannot restart a sweep
               if (cal.start) begin
                  state_r <= S_SETTLE;
                  cfg_r   <= ZERO;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  fail_r  <= 1'b0;
                  cnt_r   <= '0;
                  hits_r  <= '0;
               end else begin
                  state_r <= state_r;
               end
            end
            S_SETTLE: begin
               if (cnt_r == CNT_W'(SETTLE - 1)) begin
                  state_r <= S_SAMPLE;
                  cnt_r   <= '0;
                  hits_r  <= '0;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1'b1);
               end
            end
            S_SAMPLE: begin
               // the sample on the final SAMPLE cycle is included before EVAL
               hits_r <= hits_r + HIT_W'(cal.fb);
               if (cnt_r == CNT_W'(SAMPLES - 1)) begin
                  state_r <= S_EVAL;
                  cnt_r   <= '0;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1'b1);
               end
            end
            S_EVAL: begin
               cnt_r <= '0;
               if (hits_r == HIT_W'(SAMPLES)) begin
                  state_r <= S_DONE;
                  cfg_r   <= lock_value(cfg_r);
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else if (cfg_r == ALL_ONES) begin
                  state_r <= S_FAIL;
                  busy_r  <= 1'b0;
                  fail_r  <= 1'b1;
               end else begin
                  state_r <= S_SETTLE;
                  cfg_r   <= cfg_r + W'(1'b1);
               end
            end
            default: begin
               state_r <= S_IDLE;
               cfg_r   <= ZERO;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               fail_r  <= 1'b0;
               cnt_r   <= '0;
               hits_r  <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/ra_lcb_cal.md
# ra_lcb_cal

Calibration controller for the array local clock buffer: sweeps the `LCBSDR_CONFIGWIDTH`-bit delay/width configuration word that drives `ra_lcb_sdr`'s `cfg` input. At each setting it samples a clk-synchronous pass/fail feedback from the replica strobe detector, then locks the first setting that passes every sample. It sits beside each array shard's LCB and runs once after reset or on request, before normal array access.

## Interface
- `SETTLE`, 4, cycles waited after each `cfg` change before sampling (≥1)
- `SAMPLES`, 8, consecutive `fb` samples taken per setting (≥1)
- `MARGIN`, 1, guard-band steps added to the locked setting (only with `LCBCAL_MARGIN_EN`)
- `clk`  in  1  array clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request calibration; single-cycle or level; sampled in IDLE/DONE/FAIL only
- `fb`  in  1  replica strobe detector result, synchronous to `clk`; 1 = strobe good this cycle
- `cfg`  out  [0:`LCBSDR_CONFIGWIDTH-1]  configuration word to LCB; bit 0 is MSB
- `busy`  out  1  sweep in progress
- `done`  out  1  calibration locked; `cfg` holds final value
- `fail`  out  1  no setting passed; `cfg` held at all-ones

## Operation
- States: IDLE, SETTLE, SAMPLE, EVAL, DONE, FAIL. All outputs registered.
- IDLE: `cfg`=0, flags low. `start`=1 → SETTLE with `cfg`=0, `busy`=1.
- SETTLE: settle counter counts `SETTLE` cycles, then → SAMPLE; hit counter cleared.
- SAMPLE: for `SAMPLES` cycles, hit counter increments when `fb`=1; `fb` ignored in all other states. Hit counter width clog2(`SAMPLES`+1); cannot overflow.
- EVAL (1 cycle): pass iff hits == `SAMPLES`.
  - pass → DONE; `cfg` ← locked value; `busy`=0, `done`=1.
  - fail and `cfg` < all-ones → `cfg` ← `cfg`+1, → SETTLE.
  - fail and `cfg` == all-ones → FAIL; `cfg` stays all-ones; `busy`=0, `fail`=1. No wrap to 0.
- DONE/FAIL: outputs held indefinitely. `start`=1 → clears `done`/`fail`, `cfg`=0, `busy`=1, → SETTLE (full re-sweep).
- `start` while `busy`=1 is ignored; sweep is not restarted.
- `done` and `fail` are never high together; neither is high while `busy`=1.

## Timing
- Reset values: `cfg`=0, `busy`=0, `done`=0, `fail`=0; state IDLE; counters 0.
- `reset` wins over everything in the same cycle, including mid-sweep and in DONE/FAIL; state IDLE after the edge.
- `start` sampled high at edge t → `busy`=1 and `cfg`=0 visible after edge t.
- Per setting: `SETTLE` + `SAMPLES` + 1 cycles. Each `cfg` change is visible for ≥ `SETTLE` cycles before the first sample.
- First pass at setting k → `done`=1 and final `cfg` visible after edge t+(k+1)·(`SETTLE`+`SAMPLES`+1); `busy` falls on the same edge.
- No pass → `fail`=1 after edge t+2^W·(`SETTLE`+`SAMPLES`+1), where W=`LCBSDR_CONFIGWIDTH`.
- A single `fb`=0 inside the SAMPLE window fails that setting. The fb sample taken on the last SAMPLE cycle counts.

## Configuration
- `LCBCAL_MARGIN_EN` defined: locked `cfg` = min(k + `MARGIN`, all-ones), saturating, never wrapping.
- Not defined: locked `cfg` = k; `MARGIN` unused; no adder is built.
- FAIL behaviour is identical in both builds.

## Test plan
Bench uses `LCBSDR_CONFIGWIDTH`=4, `SETTLE`=4, `SAMPLES`=8, `MARGIN`=1.
- `fb` high only when `cfg`≥3, `start` pulsed at edge t → `done` at t+52, `cfg`=3 (4 with `LCBCAL_MARGIN_EN`), `busy` high t+1..t+51, `fail`=0.
- `fb` never high → `fail` at t+208, `cfg`=15, `done`=0. With macro defined and `fb` passing only at `cfg`=15 → `done`, `cfg`=15 (saturated, not 0).
- At `cfg`=2 `fb` is high except for one low cycle on the 8th SAMPLE cycle; `fb` is fully good for `cfg`≥3 → setting 2 rejected, lock `cfg`=3.
- `fb` glitches low during SETTLE only, at every setting → ignored, `done` at t+13, `cfg`=0 (1 with macro).
- Assert `reset` at cycle 20 of a sweep → next cycle all outputs 0, IDLE; a new `start` re-sweeps from `cfg`=0 with full timing.
- `start` held high through a sweep → no restart mid-sweep. In DONE with `start` still high → immediate re-sweep: `done` drops, `cfg`=0, `busy`=1 the next cycle.
